// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, parameter
// defaults and the exception-vector byte addresses.
package mem_pkg;

    // Default geometry and timing
    localparam int unsigned DEPTH_BYTES_DEF = 256;
    localparam int unsigned LATENCY_DEF     = 2;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Exception-vector byte addresses at the top of the default byte space
    localparam int unsigned EXC_VEC_0 = 253;
    localparam int unsigned EXC_VEC_1 = 254;
    localparam int unsigned EXC_VEC_2 = 255;

    // Big-endian assembly: lane k lands in bits [31-8k : 24-8k]
    function automatic logic [31:0] pack_be(input logic [3:0][7:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Big-endian split: bits [31-8k : 24-8k] go to lane k
    function automatic logic [3:0][7:0] split_be(input logic [31:0] w);
        logic [3:0][7:0] b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Byte-wide storage with four asynchronous read lanes and four write lanes
// sharing one write enable. Contents are deliberately not reset.
module mem_byte_ram #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic                  clk,
    input  logic [3:0][AW-1:0]    rd_idx,
    output logic [3:0][7:0]       rd_data,
    input  logic                  we,
    input  logic [3:0][AW-1:0]    wr_idx,
    input  logic [3:0][7:0]       wr_data
);

    logic [7:0] mem_q [DEPTH_BYTES];

    // Commit all four write lanes together; indices are always distinct
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[wr_idx[k]] <= wr_data[k];
            end
        end
    end

    // Combinational read of the four lanes
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            rd_data[k] = mem_q[rd_idx[k]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with fixed request-to-response
// latency. Optional feature macro: MEM_MISALIGN_TRAP_EN (trap unaligned
// accesses instead of performing them).
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int unsigned LATENCY     = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        misaligned
);

    localparam int unsigned AW     = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q_addr, mis_d_addr;
    logic          commit_we;
    logic [3:0][AW-1:0] rd_idx, wr_idx;
    logic [3:0][7:0]    rd_bytes;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    // Upper address bits are intentionally dropped by the modulo indexing
    assign unused_addr_bits = ^req_addr[31:AW];

    // Reset asserts immediately, releases only after two clean clk edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[AW-1:0];
                    write_d = req_write;
                    wdata_d = wdata;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request/FSM registers; storage itself is left alone by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_q_addr = (addr_q[1:0] != 2'b00);
    assign mis_d_addr = (addr_d[1:0] != 2'b00);
`else
    assign mis_q_addr = 1'b0;
    assign mis_d_addr = 1'b0;
`endif

    // Write commits on the edge entering RESP. The _d view is used so a
    // LATENCY=1 accept (same edge) sees the incoming request fields.
    assign commit_we = (state_d == ST_RESP) && (state_q != ST_RESP)
                       && write_d && !mis_d_addr;

    // Byte lanes wrap modulo the storage size through AW-bit arithmetic
    always_comb begin
        rd_idx = '0;
        wr_idx = '0;
        for (int k = 0; k < 4; k++) begin
            rd_idx[k] = addr_q + AW'(k);
            wr_idx[k] = addr_d + AW'(k);
        end
    end

    mem_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .rd_idx  (rd_idx),
        .rd_data (rd_bytes),
        .we      (commit_we),
        .wr_idx  (wr_idx),
        .wr_data (split_be(wdata_d))
    );

    assign rd_word = pack_be(rd_bytes);

    // Response outputs are zero outside RESP; reads only drive data
    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign misaligned = rsp_valid && mis_q_addr;
    assign rdata      = (rsp_valid && !write_q && !mis_q_addr) ? rd_word : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default DEPTH_BYTES=256, LATENCY=2.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misaligned;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rdata      (rdata),
        .misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, scramble inputs, wait for the response pulse
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic mis, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        wdata     = d;
        chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'hFFFF_FFFF;
        wdata     = ~d;
        lat = 0;
        rd  = '0;
        mis = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = 99;
        rd  = rdata;
        mis = misaligned;
        @(negedge clk);
        chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          acc_cyc[3];
    int          nacc, npulse, nbad;

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wdata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Write then read back at 0x10
        txn(1'b1, 32'h10, 32'hDEADBEEF, rd, mis, lat);
        chk("wr10_latency", lat, 32'd2);
        chk("wr10_rdata_zero", rd, 32'd0);
        chk("wr10_mis", {31'b0, mis}, 32'd0);
        txn(1'b0, 32'h10, 32'h0, rd, mis, lat);
        chk("rd10_latency", lat, 32'd2);
        chk("rd10_rdata", rd, 32'hDEADBEEF);
        chk("rd10_byte0", {24'b0, rd[31:24]}, 32'hDE);

        // Upper address bits ignored
        txn(1'b0, 32'h0000_0110, 32'h0, rd, mis, lat);
        chk("rd110_alias", rd, 32'hDEADBEEF);

        // Wrap-around: bytes 253..255 = 11 22 33, byte 0 = 44
        txn(1'b1, 32'd252, 32'h00112233, rd, mis, lat);
        txn(1'b1, 32'd0,   32'h44556677, rd, mis, lat);
        txn(1'b0, 32'd253, 32'h0, rd, mis, lat);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rd253_trap_rdata", rd, 32'h0);
        chk("rd253_trap_mis", {31'b0, mis}, 32'd1);
`else
        chk("rd253_wrap", rd, 32'h11223344);
        chk("rd253_mis", {31'b0, mis}, 32'd0);
`endif

        // req_valid held high for three back-to-back reads of 0x10
        nacc = 0;
        npulse = 0;
        nbad = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready) begin
                acc_cyc[nacc] = i;
                nacc++;
            end
            if (rsp_valid) begin
                npulse++;
                if (rdata !== 32'hDEADBEEF || req_ready) nbad++;
            end
            @(posedge clk);
            #1;
            if (nacc == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_accepts", nacc, 32'd3);
        chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
        chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        chk("b2b_pulses", npulse, 32'd3);
        chk("b2b_rsp_bad", nbad, 32'd0);

        // Reset during WAIT of a write abandons it without touching memory
        txn(1'b1, 32'h20, 32'hCAFEF00D, rd, mis, lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        wdata     = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("wait_not_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        npulse = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) npulse++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) npulse++;
        end
        chk("abandon_no_rsp", npulse, 32'd0);
        txn(1'b0, 32'h20, 32'h0, rd, mis, lat);
        chk("abandon_old_data", rd, 32'hCAFEF00D);

        // Unaligned write of 0xAAAAAAAA at 0x21
        txn(1'b1, 32'h24, 32'h00000000, rd, mis, lat);
        txn(1'b1, 32'h21, 32'hAAAAAAAA, rd, mis, lat);
        chk("wr21_latency", lat, 32'd2);
        chk("wr21_rdata", rd, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("wr21_mis", {31'b0, mis}, 32'd1);
        txn(1'b0, 32'h20, 32'h0, rd, mis, lat);
        chk("rd20_after21", rd, 32'hCAFEF00D);
        txn(1'b0, 32'h24, 32'h0, rd, mis, lat);
        chk("rd24_after21", rd, 32'h00000000);
`else
        chk("wr21_mis", {31'b0, mis}, 32'd0);
        txn(1'b0, 32'h20, 32'h0, rd, mis, lat);
        chk("rd20_after21", rd, 32'hCAAAAAAA);
        txn(1'b0, 32'h24, 32'h0, rd, mis, lat);
        chk("rd24_after21", rd, 32'hAA000000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
